regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the core 8-bit general-purpose register file.
- Provides two registered read ports and one byte write port, with write-first bypass.
- Adds AVR-style 16-bit pointer pairs (X/Y/Z) with post-increment, pre-decrement and load.
- Clears the register array with a self-sequenced clear after reset or on request, so the array needs no reset fan-out.
- Sits between the instruction decoder, the ALU operand muxes and the data-memory address unit.

Parameters:
DATA_W, 8, register width in bits
DEPTH, 32, number of registers; must be a power of 2 and at least 8
ADDR_W, $clog2(DEPTH), register address width
PAIR_BASE, DEPTH-6, index of XL; pairs are X=PAIR_BASE/+1, Y=+2/+3, Z=+4/+5, low byte at the even index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en_rd  in  1  read enable for both read ports
ra_addr  in  ADDR_W  operand 1 address
rd_addr  in  ADDR_W  operand 2 address
ra_data  out  DATA_W  operand 1 data, registered
rd_data  out  DATA_W  operand 2 data, registered
en_wd  in  1  byte write enable
wd_addr  in  ADDR_W  byte write address
wd_data  in  DATA_W  byte write data
ptr_en  in  1  pointer operation request
ptr_sel  in  2  0=X, 1=Y, 2=Z, 3=illegal
ptr_mode  in  2  0=read, 1=post-inc, 2=pre-dec, 3=load
ptr_wdata  in  2*DATA_W  load value for mode 3
ptr_addr  out  2*DATA_W  pointer address to the memory unit, registered
ptr_err  out  1  one-cycle pulse on an illegal ptr_sel
clr_req  in  1  request a full array clear
busy  out  1  clear sequence in progress

Behaviour:
- Reset (async assert, sync deassert internally): ra_data=0, rd_data=0, ptr_addr=0, ptr_err=0, busy=1, FSM=CLEAR, clear counter=0.
- FSM CLEAR: each cycle writes 0 to array[counter], then counter++. After writing index DEPTH-1, go to IDLE and set busy=0. Clear takes exactly DEPTH cycles from reset release.
- While busy=1: en_rd, en_wd, ptr_en and clr_req are ignored; ra_data, rd_data and ptr_addr hold their values.
- FSM IDLE: clr_req=1 sets busy=1 on the next edge and restarts at counter 0.
- Reset mid-clear restarts the sequence from index 0.
- Reads: when en_rd=1, ra_data and rd_data update on the next edge (1-cycle latency). When en_rd=0 they hold.
- Write-first bypass: if a read address matches a byte written in the same cycle (by en_wd or by a pointer op), the new value is returned.
- Byte write: when en_wd=1, array[wd_addr] <= wd_data at the edge.
- Pointer op (ptr_en=1, ptr_sel<3): P = {array[hi], array[lo]} is read combinationally.
  - mode 0: ptr_addr <= P; no write.
  - mode 1: ptr_addr <= P; pair <= P+1.
  - mode 2: ptr_addr <= P-1; pair <= P-1.
  - mode 3: ptr_addr <= ptr_wdata; pair <= ptr_wdata.
- Pointer arithmetic is modulo 2^(2*DATA_W): 0xFFFF+1 -> 0x0000 and 0x0000-1 -> 0xFFFF at default width.
- ptr_sel=3: no update, ptr_addr holds, ptr_err=1 for one cycle.
- Back-to-back pointer ops on the same pair see the previous update, with no stall.
- Conflict: if en_wd targets a byte that a pointer op writes in the same cycle, the pointer op wins for that byte. Any non-overlapping byte write still completes.
- ptr_err is 0 whenever ptr_en=0.

Decomposition:
- Shared package regfile_pkg holds:
  - ptr_mode constants PTR_RD, PTR_INC, PTR_DEC, PTR_LD
  - ptr_sel constants SEL_X, SEL_Y, SEL_Z
  - FSM state enum {CLEAR, IDLE}
- One natural sub-module: regfile_ptr_unit, the combinational next-pointer and next-address logic for a given mode.
- The array, bypass muxes and clear FSM stay in regfile_mp.

Test Plan:
- Release rst_n, hold clr_req=0 -> busy=1 for exactly 32 cycles, then 0. Reading all addresses afterwards returns 0x00.
- Write r5=0xA7, then en_rd with ra_addr=5 and rd_addr=5 in the same cycle as a write of r5=0x3C -> both outputs read 0x3C one cycle later (bypass).
- Load X=0xFFFF (mode 3), then post-inc -> ptr_addr=0xFFFF; r26=0x00, r27=0x00 afterwards. Then pre-dec -> ptr_addr=0xFFFF and X=0xFFFF.
- Z=0x0100 with pre-dec and en_wd to r30=0x55 in the same cycle -> r30=0xFF, r31=0x00; ptr_addr=0x00FF.
- ptr_sel=3 with ptr_en=1 -> ptr_err pulses for 1 cycle; pointers and ptr_addr unchanged.
- Assert rst_n low at clear cycle 10 of a clr_req sequence, then release -> busy stays 1 for a full 32 cycles; en_wd attempts during that window are ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its pointer unit.
package regfile_pkg;

    localparam logic [1:0] PTR_RD  = 2'd0;
    localparam logic [1:0] PTR_INC = 2'd1;
    localparam logic [1:0] PTR_DEC = 2'd2;
    localparam logic [1:0] PTR_LD  = 2'd3;

    localparam logic [1:0] SEL_X   = 2'd0;
    localparam logic [1:0] SEL_Y   = 2'd1;
    localparam logic [1:0] SEL_Z   = 2'd2;
    localparam logic [1:0] SEL_BAD = 2'd3;

    typedef enum logic {
        CLEAR,
        IDLE
    } rf_state_t;

endpackage

// File: rtl/regfile_if.sv
// Bus between the decoder/ALU/address unit (master) and the register file (slave).
interface regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic                  en_rd;
    logic [ADDR_W-1:0]     ra_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     ra_data;
    logic [DATA_W-1:0]     rd_data;
    logic                  en_wd;
    logic [ADDR_W-1:0]     wd_addr;
    logic [DATA_W-1:0]     wd_data;
    logic                  ptr_en;
    logic [1:0]            ptr_sel;
    logic [1:0]            ptr_mode;
    logic [2*DATA_W-1:0]   ptr_wdata;
    logic [2*DATA_W-1:0]   ptr_addr;
    logic                  ptr_err;
    logic                  clr_req;
    logic                  busy;

    modport slave (
        input  en_rd, ra_addr, rd_addr,
        input  en_wd, wd_addr, wd_data,
        input  ptr_en, ptr_sel, ptr_mode, ptr_wdata,
        input  clr_req,
        output ra_data, rd_data, ptr_addr, ptr_err, busy
    );

    modport master (
        output en_rd, ra_addr, rd_addr,
        output en_wd, wd_addr, wd_data,
        output ptr_en, ptr_sel, ptr_mode, ptr_wdata,
        output clr_req,
        input  ra_data, rd_data, ptr_addr, ptr_err, busy
    );
endinterface

// File: rtl/regfile_ptr_unit.sv
// Combinational next-pointer / next-address logic for one 16-bit pointer pair.
module regfile_ptr_unit
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]          i_mode,
    input  logic [2*DATA_W-1:0] i_ptr,
    input  logic [2*DATA_W-1:0] i_ldval,
    output logic [2*DATA_W-1:0] o_next_ptr,
    output logic [2*DATA_W-1:0] o_next_addr,
    output logic                o_wr
);
    localparam int PW = 2 * DATA_W;
    localparam logic [PW-1:0] ONE = PW'(1);

    // Arithmetic wraps naturally at PW bits.
    always_comb begin
        o_next_ptr  = i_ptr;
        o_next_addr = i_ptr;
        o_wr        = 1'b0;
        case (i_mode)
            PTR_RD: begin
                o_next_addr = i_ptr;
            end
            PTR_INC: begin
                o_next_addr = i_ptr;
                o_next_ptr  = i_ptr + ONE;
                o_wr        = 1'b1;
            end
            PTR_DEC: begin
                o_next_ptr  = i_ptr - ONE;
                o_next_addr = i_ptr - ONE;
                o_wr        = 1'b1;
            end
            default: begin
                o_next_ptr  = i_ldval;
                o_next_addr = i_ldval;
                o_wr        = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// General-purpose register file: two registered read ports, one byte write port,
// X/Y/Z pointer pairs with inc/dec/load, and a self-sequenced array clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int PAIR_BASE = DEPTH - 6
) (
    input  logic     clk,
    input  logic     rst_n,
    regfile_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PAIR_BASE_A = ADDR_W'(PAIR_BASE);

    logic [DATA_W-1:0] r_mem [DEPTH];

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;

    logic [DATA_W-1:0] r_ra_data;
    logic [DATA_W-1:0] r_rd_data;
    logic [PW-1:0]     r_ptr_addr;
    logic              r_ptr_err;

    logic              w_busy;
    logic              w_rd_act;
    logic              w_wd_act;
    logic              w_wd_keep;
    logic              w_ptr_act;
    logic              w_ptr_bad;
    logic              w_ptr_wr;
    logic              w_ptr_wr_act;
    logic [ADDR_W-1:0] w_lo_idx;
    logic [ADDR_W-1:0] w_hi_idx;
    logic [PW-1:0]     w_ptr_cur;
    logic [PW-1:0]     w_ptr_nxt;
    logic [PW-1:0]     w_ptr_addr_nxt;
    logic [DATA_W-1:0] w_ra_fwd;
    logic [DATA_W-1:0] w_rd_fwd;

    // Write-first: a byte written this cycle is returned instead of the stored value;
    // the pointer write takes priority over the byte port on the same byte.
    function automatic logic [DATA_W-1:0] fwd_byte(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              ptr_wr,
        input logic [ADDR_W-1:0] lo,
        input logic [ADDR_W-1:0] hi,
        input logic [PW-1:0]     pnew,
        input logic              wd_wr,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wdat
    );
        if (ptr_wr && (a == lo)) return pnew[DATA_W-1:0];
        if (ptr_wr && (a == hi)) return pnew[PW-1:DATA_W];
        if (wd_wr && (a == wa))  return wdat;
        return stored;
    endfunction

    assign w_busy    = (r_state == CLEAR);
    assign w_rd_act  = !w_busy && bus.en_rd;
    assign w_wd_act  = !w_busy && bus.en_wd;
    assign w_ptr_act = !w_busy && bus.ptr_en && (bus.ptr_sel != SEL_BAD);
    assign w_ptr_bad = !w_busy && bus.ptr_en && (bus.ptr_sel == SEL_BAD);

    assign w_lo_idx  = PAIR_BASE_A + ADDR_W'({bus.ptr_sel, 1'b0});
    assign w_hi_idx  = w_lo_idx + ADDR_W'(1);
    assign w_ptr_cur = {r_mem[w_hi_idx], r_mem[w_lo_idx]};

    regfile_ptr_unit #(
        .DATA_W (DATA_W)
    ) u_ptr (
        .i_mode      (bus.ptr_mode),
        .i_ptr       (w_ptr_cur),
        .i_ldval     (bus.ptr_wdata),
        .o_next_ptr  (w_ptr_nxt),
        .o_next_addr (w_ptr_addr_nxt),
        .o_wr        (w_ptr_wr)
    );

    assign w_ptr_wr_act = w_ptr_act && w_ptr_wr;
    assign w_wd_keep    = w_wd_act &&
                          !(w_ptr_wr_act && ((bus.wd_addr == w_lo_idx) || (bus.wd_addr == w_hi_idx)));

    assign w_ra_fwd = fwd_byte(bus.ra_addr, r_mem[bus.ra_addr], w_ptr_wr_act, w_lo_idx, w_hi_idx,
                               w_ptr_nxt, w_wd_act, bus.wd_addr, bus.wd_data);
    assign w_rd_fwd = fwd_byte(bus.rd_addr, r_mem[bus.rd_addr], w_ptr_wr_act, w_lo_idx, w_hi_idx,
                               w_ptr_nxt, w_wd_act, bus.wd_addr, bus.wd_data);

    // Clear FSM: one array entry zeroed per cycle, DEPTH cycles total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == LAST_IDX) w_state_nxt = IDLE;
            end
            default: begin
                if (bus.clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
        endcase
    end

    // Array storage carries no reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else begin
            if (w_wd_keep) r_mem[bus.wd_addr] <= bus.wd_data;
            if (w_ptr_wr_act) begin
                r_mem[w_lo_idx] <= w_ptr_nxt[DATA_W-1:0];
                r_mem[w_hi_idx] <= w_ptr_nxt[PW-1:DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra_data  <= '0;
            r_rd_data  <= '0;
            r_ptr_addr <= '0;
            r_ptr_err  <= 1'b0;
        end else begin
            if (w_rd_act) begin
                r_ra_data <= w_ra_fwd;
                r_rd_data <= w_rd_fwd;
            end
            if (w_ptr_act) r_ptr_addr <= w_ptr_addr_nxt;
            r_ptr_err <= w_ptr_bad;
        end
    end

    assign bus.ra_data  = r_ra_data;
    assign bus.rd_data  = r_rd_data;
    assign bus.ptr_addr = r_ptr_addr;
    assign bus.ptr_err  = r_ptr_err;
    assign bus.busy     = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 32;
    localparam int ADDR_W    = 5;
    localparam int PAIR_BASE = 26;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: array contents, remaining clear cycles, expected outputs.
    logic [7:0]  m_mem [DEPTH];
    int          m_clear_left;
    logic [7:0]  e_ra, e_rd;
    logic [15:0] e_paddr;
    logic        e_err;
    bit          chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ra_data",  32'(bus.ra_data),  32'(e_ra));
            check("rd_data",  32'(bus.rd_data),  32'(e_rd));
            check("ptr_addr", 32'(bus.ptr_addr), 32'(e_paddr));
            check("ptr_err",  32'(bus.ptr_err),  32'(e_err));
            check("busy",     32'(bus.busy),     32'(m_clear_left > 0));
        end
    end

    task automatic model_reset();
        m_clear_left = DEPTH;
        e_ra = 8'h00; e_rd = 8'h00; e_paddr = 16'h0000; e_err = 1'b0;
    endtask

    // Array-level view: apply this edge's writes, then reads see the new array.
    task automatic model_edge();
        logic [7:0] nm [DEPTH];
        int lo, p, newp;
        bit pw;
        if (!rst_n) return;
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = 8'h00;
            m_clear_left--;
            e_err = 1'b0;
            return;
        end
        nm = m_mem;
        pw = 0;
        newp = 0;
        e_err = bus.ptr_en && (bus.ptr_sel == 2'd3);
        if (bus.en_wd) nm[bus.wd_addr] = bus.wd_data;
        if (bus.ptr_en && bus.ptr_sel != 2'd3) begin
            lo = PAIR_BASE + 2 * int'(bus.ptr_sel);
            p  = int'(m_mem[lo]) + 256 * int'(m_mem[lo+1]);
            case (bus.ptr_mode)
                2'd0: e_paddr = 16'(p);
                2'd1: begin newp = (p + 1) % 65536; e_paddr = 16'(p); pw = 1; end
                2'd2: begin newp = (p + 65535) % 65536; e_paddr = 16'(newp); pw = 1; end
                default: begin newp = int'(bus.ptr_wdata); e_paddr = 16'(newp); pw = 1; end
            endcase
            if (pw) begin
                nm[lo]   = 8'(newp % 256);
                nm[lo+1] = 8'(newp / 256);
            end
        end
        if (bus.en_rd) begin
            e_ra = nm[bus.ra_addr];
            e_rd = nm[bus.rd_addr];
        end
        m_mem = nm;
        if (bus.clr_req) m_clear_left = DEPTH;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.en_rd = 0; bus.ra_addr = '0; bus.rd_addr = '0;
        bus.en_wd = 0; bus.wd_addr = '0; bus.wd_data = '0;
        bus.ptr_en = 0; bus.ptr_sel = '0; bus.ptr_mode = '0; bus.ptr_wdata = '0;
        bus.clr_req = 0;
    endtask

    task automatic rand_inputs();
        int k;
        bus.en_rd   = 1'($urandom);
        bus.ra_addr = ($urandom_range(0, 1) == 1) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom);
        bus.rd_addr = 5'($urandom);
        bus.en_wd   = 1'($urandom);
        bus.wd_addr = ($urandom_range(0, 1) == 1) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom);
        bus.wd_data = 8'($urandom);
        bus.ptr_en  = 1'($urandom);
        bus.ptr_sel = 2'($urandom);
        bus.ptr_mode = 2'($urandom);
        k = $urandom_range(0, 3);
        bus.ptr_wdata = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h0000 : 16'($urandom);
        bus.clr_req = ($urandom_range(0, 63) == 0);
    endtask

    task automatic ptr_op(input logic [1:0] sel, input logic [1:0] mode, input logic [15:0] val);
        idle_inputs();
        bus.ptr_en = 1; bus.ptr_sel = sel; bus.ptr_mode = mode; bus.ptr_wdata = val;
        step();
    endtask

    task automatic read2(input int a, input int b);
        idle_inputs();
        bus.en_rd = 1; bus.ra_addr = 5'(a); bus.rd_addr = 5'(b);
        step();
    endtask

    task automatic count_busy(input string name, input bit write_attempts);
        int n = 0;
        while (bus.busy && n < 100) begin
            idle_inputs();
            if (write_attempts) begin
                bus.en_wd = 1; bus.wd_addr = 5'($urandom); bus.wd_data = 8'($urandom_range(1, 255));
                bus.ptr_en = 1; bus.ptr_mode = 2'd3; bus.ptr_wdata = 16'hBEEF; bus.en_rd = 1;
            end
            step();
            n++;
        end
        check(name, 32'(n), 32'd32);
    endtask

    initial begin
        idle_inputs();
        #1;
        rst_n = 0;
        model_reset();
        chk_en = 1;
        repeat (3) step();
        check("rst_ra", 32'(bus.ra_data), 32'h0);
        check("rst_paddr", 32'(bus.ptr_addr), 32'h0);
        rst_n = 1;
        count_busy("busy_cycles", 1'b0);
        for (int a = 0; a < DEPTH; a++) begin
            read2(a, DEPTH - 1 - a);
            check("clr_ra", 32'(bus.ra_data), 32'h00);
            check("clr_rd", 32'(bus.rd_data), 32'h00);
        end

        // Bypass: read r5 in the same cycle it is rewritten.
        idle_inputs(); bus.en_wd = 1; bus.wd_addr = 5'd5; bus.wd_data = 8'hA7; step();
        idle_inputs(); bus.en_wd = 1; bus.wd_addr = 5'd5; bus.wd_data = 8'h3C;
        bus.en_rd = 1; bus.ra_addr = 5'd5; bus.rd_addr = 5'd5; step();
        check("byp_ra", 32'(bus.ra_data), 32'h3C);
        check("byp_rd", 32'(bus.rd_data), 32'h3C);

        // X wraps at both ends.
        ptr_op(2'd0, 2'd3, 16'hFFFF);
        check("x_ld", 32'(bus.ptr_addr), 32'hFFFF);
        ptr_op(2'd0, 2'd1, 16'h0000);
        check("x_inc", 32'(bus.ptr_addr), 32'hFFFF);
        read2(26, 27);
        check("x_lo0", 32'(bus.ra_data), 32'h00);
        check("x_hi0", 32'(bus.rd_data), 32'h00);
        ptr_op(2'd0, 2'd2, 16'h0000);
        check("x_dec", 32'(bus.ptr_addr), 32'hFFFF);
        read2(26, 27);
        check("x_loF", 32'(bus.ra_data), 32'hFF);
        check("x_hiF", 32'(bus.rd_data), 32'hFF);

        // Z pre-dec colliding with a byte write to r30.
        ptr_op(2'd2, 2'd3, 16'h0100);
        idle_inputs();
        bus.ptr_en = 1; bus.ptr_sel = 2'd2; bus.ptr_mode = 2'd2;
        bus.en_wd = 1; bus.wd_addr = 5'd30; bus.wd_data = 8'h55;
        step();
        check("z_dec", 32'(bus.ptr_addr), 32'h00FF);
        read2(30, 31);
        check("z_lo", 32'(bus.ra_data), 32'hFF);
        check("z_hi", 32'(bus.rd_data), 32'h00);

        // Illegal select.
        ptr_op(2'd3, 2'd1, 16'h1111);
        check("err_pulse", 32'(bus.ptr_err), 32'h1);
        check("err_hold", 32'(bus.ptr_addr), 32'h00FF);
        idle_inputs(); step();
        check("err_clear", 32'(bus.ptr_err), 32'h0);
        read2(30, 27);
        check("err_z", 32'(bus.ra_data), 32'hFF);
        check("err_x", 32'(bus.rd_data), 32'hFF);

        // Back-to-back ops on Y.
        ptr_op(2'd1, 2'd3, 16'h1234);
        ptr_op(2'd1, 2'd1, 16'h0000);
        check("y_inc1", 32'(bus.ptr_addr), 32'h1234);
        ptr_op(2'd1, 2'd1, 16'h0000);
        check("y_inc2", 32'(bus.ptr_addr), 32'h1235);
        ptr_op(2'd1, 2'd2, 16'h0000);
        check("y_dec", 32'(bus.ptr_addr), 32'h1235);

        // Clear request interrupted by reset at clear cycle 10.
        idle_inputs(); bus.clr_req = 1; step();
        check("clr_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 10; i++) begin
            idle_inputs(); bus.en_wd = 1; bus.wd_addr = 5'($urandom); bus.wd_data = 8'hEE;
            step();
        end
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) step();
        rst_n = 1;
        count_busy("busy_after_rst", 1'b1);
        for (int a = 0; a < DEPTH; a += 2) begin
            read2(a, a + 1);
            check("clr2_ra", 32'(bus.ra_data), 32'h00);
            check("clr2_rd", 32'(bus.rd_data), 32'h00);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
